// File: rtl/leaf_router.sv
// leaf_router: group-level router joining four leaf links and one uplink.
// Per-input FIFOs, header steering, round-robin arbitration per output port.
module leaf_router #(
   parameter int unsigned GROUP_ID   = 8,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4*DATA_W-1:0] leaf_data_in,
   input  logic [3:0]          leaf_valid_in,
   output logic [3:0]          leaf_ready_out,
   output logic [4*DATA_W-1:0] leaf_data_out,
   output logic [3:0]          leaf_valid_out,
   input  logic [DATA_W-1:0]   up_data_in,
   input  logic                up_valid_in,
   output logic                up_ready_out,
   output logic [DATA_W-1:0]   up_data_out,
   output logic                up_valid_out,
   input  logic                up_ready_in,
   output logic [7:0]          drop_count
);

   localparam int unsigned N_PORT  = 5;
   localparam int unsigned UP      = 4;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned HDR_LSB = DATA_W - 6;

   logic [DATA_W-1:0] mem      [N_PORT][FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr   [N_PORT];
   logic [PTR_W-1:0]  wr_ptr   [N_PORT];
   logic [CNT_W-1:0]  count    [N_PORT];
   logic [SEL_W-1:0]  rr_next  [N_PORT];

   logic [DATA_W-1:0] in_data  [N_PORT];
   logic [N_PORT-1:0] in_valid;
   logic [DATA_W-1:0] head     [N_PORT];
   logic [N_PORT-1:0] head_vld;
   logic [N_PORT-1:0] head_drop;
   logic [SEL_W-1:0]  head_dst [N_PORT];
   logic [N_PORT-1:0] req      [N_PORT];
   logic [N_PORT-1:0] gnt_vld;
   logic [SEL_W-1:0]  gnt_idx  [N_PORT];
   logic [N_PORT-1:0] pop;
   logic [N_PORT-1:0] push;
   logic [N_PORT-1:0] ovf;
   logic [3:0]        drop_events;
   logic [8:0]        drop_sum;

   function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                 input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= N_PORT) s = s - N_PORT;
      return SEL_W'(s);
   endfunction

   // Flatten the five input links into one indexable view (uplink is index 4).
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         in_data[i] = leaf_data_in[i*DATA_W +: DATA_W];
      end
      in_data[UP] = up_data_in;
      in_valid    = {up_valid_in, leaf_valid_in};
   end

   // Head decode: local group -> leaf, group 0 or foreign-from-uplink -> drop, else uplink.
   always_comb begin
      for (int i = 0; i < N_PORT; i++) begin
         head[i]      = mem[i][rd_ptr[i]];
         head_vld[i]  = (count[i] != '0);
         head_dst[i]  = SEL_W'(UP);
         head_drop[i] = 1'b0;
         if (head[i][DATA_W-1 -: 4] == 4'(GROUP_ID)) begin
            head_dst[i] = {1'b0, head[i][HDR_LSB +: 2]};
         end else if (i == UP || head[i][DATA_W-1 -: 4] == 4'h0) begin
            head_drop[i] = head_vld[i];
         end
      end
   end

   always_comb begin
      for (int o = 0; o < N_PORT; o++) begin
         for (int i = 0; i < N_PORT; i++) begin
            req[o][i] = head_vld[i] && !head_drop[i] && (head_dst[i] == SEL_W'(o));
         end
      end
   end

   // Round-robin: scan offsets high to low so the nearest requester after rr_next wins.
   always_comb begin
      for (int o = 0; o < N_PORT; o++) begin
         gnt_vld[o] = 1'b0;
         gnt_idx[o] = '0;
         for (int k = N_PORT - 1; k >= 0; k--) begin
            if (req[o][wrap_idx(rr_next[o], k)]) begin
               gnt_vld[o] = 1'b1;
               gnt_idx[o] = wrap_idx(rr_next[o], k);
            end
         end
         if (o == UP && !up_ready_in) gnt_vld[o] = 1'b0;
      end
   end

   always_comb begin
      pop = head_drop;
      for (int o = 0; o < N_PORT; o++) begin
         if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
      end
   end

   always_comb begin
      push        = '0;
      ovf         = '0;
      drop_events = '0;
      for (int i = 0; i < N_PORT; i++) begin
         push[i]     = in_valid[i] && (count[i] != CNT_W'(FIFO_DEPTH));
         ovf[i]      = in_valid[i] && (count[i] == CNT_W'(FIFO_DEPTH));
         drop_events = drop_events + 4'(head_drop[i]) + 4'(ovf[i]);
      end
      drop_sum = {1'b0, drop_count} + 9'(drop_events);
   end

   // Ready keeps one slot free for the flit already in flight.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         leaf_ready_out[i] = !reset && (count[i] <= CNT_W'(FIFO_DEPTH - 2));
      end
      up_ready_out = !reset && (count[UP] <= CNT_W'(FIFO_DEPTH - 2));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_PORT; i++) begin
            rd_ptr[i]  <= '0;
            wr_ptr[i]  <= '0;
            count[i]   <= '0;
            rr_next[i] <= '0;
         end
         leaf_data_out  <= '0;
         leaf_valid_out <= '0;
         up_data_out    <= '0;
         up_valid_out   <= 1'b0;
         drop_count     <= '0;
      end else begin
         for (int i = 0; i < N_PORT; i++) begin
            if (push[i]) begin
               mem[i][wr_ptr[i]] <= in_data[i];
               wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
            end
            if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CNT_W'(1);
               2'b01:   count[i] <= count[i] - CNT_W'(1);
               default: ;
            endcase
            if (gnt_vld[i]) rr_next[i] <= wrap_idx(gnt_idx[i], 1);
         end
         for (int o = 0; o < 4; o++) begin
            leaf_valid_out[o] <= gnt_vld[o];
            if (gnt_vld[o]) leaf_data_out[o*DATA_W +: DATA_W] <= head[gnt_idx[o]];
         end
         up_valid_out <= gnt_vld[UP];
         if (gnt_vld[UP]) up_data_out <= head[gnt_idx[UP]];
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule
